frost32_mem_arbiter: RTL

//  Shares the single Frost32 memory port between the decode-stage instruction

---
 rtl/frost32_mem_arbiter_pkg.sv | 20 ++
 rtl/frost32_starve_counter.sv | 29 ++
 rtl/frost32_mem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/frost32_mem_arbiter_pkg.sv
// Shared types and encodings for the Frost32 memory arbiter: FSM states,
// request owners, access type/size encodings and the alignment rule.
package frost32_mem_arbiter_pkg;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} MemArbState;
    typedef enum logic {OwnFetch, OwnData} MemArbOwner;

    localparam logic DiatRead  = 1'b0;
    localparam logic DiatWrite = 1'b1;

    localparam logic [1:0] Dias32 = 2'd0;
    localparam logic [1:0] Dias16 = 2'd1;
    localparam logic [1:0] Dias8  = 2'd2;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == Dias32) && (addr_lo != 2'b00)) ||
               ((size == Dias16) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/frost32_starve_counter.sv
// Saturating count of consecutive fetch losses; at_limit forces the next
// contested grant to the fetch side.
module frost32_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    assign at_limit = (cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frost32_mem_arbiter.sv
// Arbitrates the single Frost32 memory port between instruction fetch and
// load/store, latches the winner onto the bus and returns a one-cycle done.
module frost32_mem_arbiter
    import frost32_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_done,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic                  data_we,
    input  logic [1:0]            data_size,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_done,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_misaligned,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [1:0]            mem_size,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    MemArbState state, state_next;
    MemArbOwner owner;

    logic at_limit;
    logic fetch_wins;
    logic data_wins;
    logic data_bad;
    logic starve_inc;
    logic starve_clr;

    frost32_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .at_limit(at_limit)
    );

    assign busy = (state != StIdle);

    always_comb begin
        fetch_wins = fetch_req && (!data_req || at_limit);
        data_wins  = data_req && !fetch_wins;
        data_bad   = is_misaligned(data_size, data_addr[1:0]);
        starve_inc = (state == StIdle) && fetch_req && data_wins;
        starve_clr = (state == StIdle) && fetch_wins;
        state_next = state;
        unique case (state)
            StIdle: begin
                if (data_wins && data_bad) begin
                    state_next = StResp;
                end else if (fetch_wins || data_wins) begin
                    state_next = StBusy;
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    state_next = StResp;
                end
            end
            StResp:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner           <= OwnFetch;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            mem_we          <= DiatRead;
            mem_size        <= Dias32;
            mem_wdata       <= '0;
            fetch_done      <= 1'b0;
            fetch_rdata     <= '0;
            data_done       <= 1'b0;
            data_rdata      <= '0;
            data_misaligned <= 1'b0;
        end else begin
            fetch_done      <= 1'b0;
            data_done       <= 1'b0;
            data_misaligned <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (fetch_wins) begin
                        owner     <= OwnFetch;
                        mem_req   <= 1'b1;
                        mem_addr  <= fetch_addr;
                        mem_we    <= DiatRead;
                        mem_size  <= Dias32;
                        mem_wdata <= '0;
                    end else if (data_wins) begin
                        // Misaligned accesses are answered locally and never reach the bus.
                        if (data_bad) begin
                            data_done       <= 1'b1;
                            data_misaligned <= 1'b1;
                            data_rdata      <= '0;
                        end else begin
                            owner     <= OwnData;
                            mem_req   <= 1'b1;
                            mem_addr  <= data_addr;
                            mem_we    <= data_we;
                            mem_size  <= data_size;
                            mem_wdata <= data_we ? data_wdata : '0;
                        end
                    end
                end
                StBusy: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (owner == OwnFetch) begin
                            fetch_done  <= 1'b1;
                            fetch_rdata <= mem_rdata;
                        end else begin
                            data_done  <= 1'b1;
                            data_rdata <= mem_we ? '0 : mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
